pc_register_unit: RTL and testbench

- Program-counter stage that sits directly downstream of the PC source multiplexer in the multicycle CPU datapath.
- Registers the selected next-PC and owns the EPC register.
- Evaluates the conditional-branch write enable from ALU flags, blocks misaligned targets, and keeps a PC-write event counter.
- Feeds the instruction-memory address path and the PC+4 adder.

---
 rtl/pc_register_unit_if.sv | 30 +++
 rtl/pc_register_unit.sv | 74 +++++++
 tb/tb_pc_register_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pc_register_unit_if.sv
// rtl/pc_register_unit_if.sv - signal bundle between control/PC mux and the PC register stage
interface pc_register_unit_if #(
  parameter int CNT_WIDTH = 32
);
  logic [31:0]          pc_in;
  logic                 pc_write;
  logic                 pc_write_cond;
  logic [1:0]           branch_op;
  logic                 alu_zero;
  logic                 alu_gt;
  logic                 epc_write;
  logic [31:0]          epc_in;
  logic [31:0]          pc_out;
  logic [31:0]          epc_out;
  logic                 branch_taken;
  logic                 pc_changed;
  logic                 align_fault;
  logic [31:0]          fault_addr;
  logic [CNT_WIDTH-1:0] write_count;

  modport master (
    output pc_in, pc_write, pc_write_cond, branch_op, alu_zero, alu_gt, epc_write, epc_in,
    input  pc_out, epc_out, branch_taken, pc_changed, align_fault, fault_addr, write_count
  );

  modport slave (
    input  pc_in, pc_write, pc_write_cond, branch_op, alu_zero, alu_gt, epc_write, epc_in,
    output pc_out, epc_out, branch_taken, pc_changed, align_fault, fault_addr, write_count
  );
endinterface

// File: rtl/pc_register_unit.sv
// rtl/pc_register_unit.sv - PC register with branch-condition gating, alignment guard, EPC and write counter
module pc_register_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  pc_register_unit_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 cond;
  logic                 req;
  logic                 aligned;
  logic [31:0]          pc;
  logic [31:0]          epc;
  logic [31:0]          fault;
  logic [CNT_WIDTH-1:0] count;
  logic                 taken_q;
  logic                 changed_q;
  logic                 fault_q;

  always_comb begin
    cond = 1'b0;
    case (bus.branch_op)
      2'b00:   cond = bus.alu_zero;
      2'b01:   cond = !bus.alu_zero;
      2'b10:   cond = bus.alu_zero | !bus.alu_gt;
      default: cond = bus.alu_gt & !bus.alu_zero;
    endcase
  end

  assign req     = bus.pc_write | (bus.pc_write_cond & cond);
  assign aligned = (bus.pc_in[1:0] == 2'b00);

  // Pulses default low every edge so they only stay high across consecutive qualifying edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      epc       <= 32'h0;
      fault     <= 32'h0;
      count     <= '0;
      taken_q   <= 1'b0;
      changed_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      taken_q   <= 1'b0;
      changed_q <= 1'b0;
      fault_q   <= 1'b0;
      if (req) begin
        if (aligned) begin
          pc        <= bus.pc_in;
          changed_q <= 1'b1;
          count     <= count + CNT_ONE;
          taken_q   <= !bus.pc_write;
        end else begin
          fault_q <= 1'b1;
          fault   <= bus.pc_in;
        end
      end
      if (bus.epc_write) begin
        epc <= bus.epc_in;
      end
    end
  end

  assign bus.pc_out       = pc;
  assign bus.epc_out      = epc;
  assign bus.fault_addr   = fault;
  assign bus.write_count  = count;
  assign bus.branch_taken = taken_q;
  assign bus.pc_changed   = changed_q;
  assign bus.align_fault  = fault_q;
endmodule

// File: tb/tb_pc_register_unit.sv
// tb/tb_pc_register_unit.sv - scoreboard bench for pc_register_unit with directed vectors
module tb_pc_register_unit;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] fa;
    logic        bt;
    logic        ch;
    logic        af;
    logic [3:0]  wc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  pc_register_unit_if #(.CNT_WIDTH(4)) bus();

  pc_register_unit #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] epc, input logic [31:0] fa,
                              input logic bt, input logic ch, input logic af, input logic [3:0] wc);
    exp_t e;
    e.pc = pc; e.epc = epc; e.fa = fa; e.bt = bt; e.ch = ch; e.af = af; e.wc = wc;
    return e;
  endfunction

  // Monitor: each pushed vector is checked at the negedge after the posedge that consumed it.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc_out",       bus.pc_out,                e.pc);
      chk("epc_out",      bus.epc_out,               e.epc);
      chk("fault_addr",   bus.fault_addr,            e.fa);
      chk("branch_taken", {31'b0, bus.branch_taken}, {31'b0, e.bt});
      chk("pc_changed",   {31'b0, bus.pc_changed},   {31'b0, e.ch});
      chk("align_fault",  {31'b0, bus.align_fault},  {31'b0, e.af});
      chk("write_count",  {28'b0, bus.write_count},  {28'b0, e.wc});
    end
  end

  task automatic drive(input logic pw, input logic pwc, input logic [1:0] op, input logic z,
                       input logic gt, input logic ew, input logic [31:0] ei, input logic [31:0] pin);
    bus.pc_write      = pw;
    bus.pc_write_cond = pwc;
    bus.branch_op     = op;
    bus.alu_zero      = z;
    bus.alu_gt        = gt;
    bus.epc_write     = ew;
    bus.epc_in        = ei;
    bus.pc_in         = pin;
  endtask

  task automatic step(input logic pw, input logic pwc, input logic [1:0] op, input logic z,
                      input logic gt, input logic ew, input logic [31:0] ei, input logic [31:0] pin,
                      input exp_t e);
    @(negedge clk);
    #1;
    drive(pw, pwc, op, z, gt, ew, ei, pin);
    q.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"},    bus.pc_out,                32'h0);
    chk({tag, "_epc"},   bus.epc_out,               32'h0);
    chk({tag, "_fa"},    bus.fault_addr,            32'h0);
    chk({tag, "_wc"},    {28'b0, bus.write_count},  32'h0);
    chk({tag, "_pulse"}, {29'b0, bus.branch_taken, bus.pc_changed, bus.align_fault}, 32'h0);
  endtask

  // Asynchronous reset between edges, checked before any clock edge can occur.
  task automatic mid_cycle_reset(input string tag);
    @(negedge clk);
    #2;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    #1;
    check_reset_state(tag);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst_hold");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 3; i++)
      step(0, 0, 2'b00, 0, 0, 0, 32'h0, 32'h0, mk(32'h0, 32'h0, 32'h0, 0, 0, 0, 4'd0));
    step(1, 0, 2'b00, 0, 0, 0, 32'h0, 32'h40, mk(32'h40, 32'h0, 32'h0, 0, 1, 0, 4'd1));
    mid_cycle_reset("rst_mid");

    step(1, 0, 2'b00, 0, 0, 0, 32'h0, 32'h4,   mk(32'h4,   0, 0, 0, 1, 0, 4'd1));
    step(0, 1, 2'b00, 1, 0, 0, 32'h0, 32'h100, mk(32'h100, 0, 0, 1, 1, 0, 4'd2));
    step(0, 1, 2'b00, 0, 0, 0, 32'h0, 32'h180, mk(32'h100, 0, 0, 0, 0, 0, 4'd2));
    step(0, 1, 2'b01, 0, 0, 0, 32'h0, 32'h104, mk(32'h104, 0, 0, 1, 1, 0, 4'd3));
    step(0, 1, 2'b10, 0, 0, 0, 32'h0, 32'h108, mk(32'h108, 0, 0, 1, 1, 0, 4'd4));
    step(0, 1, 2'b10, 0, 1, 0, 32'h0, 32'h10C, mk(32'h108, 0, 0, 0, 0, 0, 4'd4));
    step(0, 1, 2'b10, 1, 0, 0, 32'h0, 32'h110, mk(32'h110, 0, 0, 1, 1, 0, 4'd5));
    step(0, 1, 2'b11, 0, 0, 0, 32'h0, 32'h114, mk(32'h110, 0, 0, 0, 0, 0, 4'd5));
    step(0, 1, 2'b11, 0, 1, 0, 32'h0, 32'h118, mk(32'h118, 0, 0, 1, 1, 0, 4'd6));
    step(0, 1, 2'b11, 1, 0, 0, 32'h0, 32'h11C, mk(32'h118, 0, 0, 0, 0, 0, 4'd6));
    step(1, 0, 2'b00, 0, 0, 0, 32'h0, 32'h100, mk(32'h100, 0, 0, 0, 1, 0, 4'd7));
    step(1, 0, 2'b00, 0, 0, 0, 32'h0, 32'h102, mk(32'h100, 0, 32'h102, 0, 0, 1, 4'd7));
    step(0, 0, 2'b00, 0, 0, 0, 32'h0, 32'h0,   mk(32'h100, 0, 32'h102, 0, 0, 0, 4'd7));
    step(0, 1, 2'b00, 1, 0, 0, 32'h0, 32'h201, mk(32'h100, 0, 32'h201, 0, 0, 1, 4'd7));
    step(1, 1, 2'b00, 0, 0, 0, 32'h0, 32'h120, mk(32'h120, 0, 32'h201, 0, 1, 0, 4'd8));
    step(1, 0, 2'b00, 0, 0, 1, 32'h1FC, 32'h200, mk(32'h200, 32'h1FC, 32'h201, 0, 1, 0, 4'd9));
    step(0, 0, 2'b00, 0, 0, 1, 32'h300, 32'h0,   mk(32'h200, 32'h300, 32'h201, 0, 0, 0, 4'd9));

    mid_cycle_reset("rst_wrap");
    for (int i = 0; i < 16; i++)
      step(1, 0, 2'b00, 0, 0, 0, 32'h0, 32'h400 + 32'(4 * i),
           mk(32'h400 + 32'(4 * i), 0, 0, 0, 1, 0, 4'((i + 1) % 16)));
    step(0, 0, 2'b00, 0, 0, 0, 32'h0, 32'h0, mk(32'h43C, 0, 0, 0, 0, 0, 4'd0));

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected responses never checked (required 0)", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
